// File: rtl/_or16_accum_pkg.sv
// _or16_accum_pkg: state encoding and default sizing for the OR accumulator
package _or16_accum_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;
  localparam int WINDOW_DEF = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/_or16_accum_if.sv
// _or16_accum_if: input stream, flush and result handshake of the OR accumulator
interface _or16_accum_if #(
  parameter int CNT_W = 8
);
  logic in_valid;
  logic in_ready;
  logic [15:0] in_data;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [15:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic out_any;
  modport master (
    output in_valid, in_data, flush, out_ready,
    input in_ready, out_valid, out_data, out_count, out_any
  );
  modport slave (
    input in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, out_any
  );
endinterface

// File: rtl/_or16_accum_or16.sv
// _or16: 16-bit bit-wise OR combining element
module _or16 (
  input logic [15:0] a_i,
  input logic [15:0] b_i,
  output logic [15:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/_or16_accum.sv
// _or16_accum: sticky OR over a window of accepted beats, one result per window.
// Define OR16_ACCUM_OVERLAP_EN to accept a new beat on the result handshake cycle.
module _or16_accum
  import _or16_accum_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  _or16_accum_if.slave bus
);
  state_e state_q, state_d;
  logic [15:0] acc_q, acc_d, merged, out_data_q, out_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, out_count_q, out_count_d;
  logic hold_ready, accept, close_beat;
`ifdef OR16_ACCUM_OVERLAP_EN
  assign hold_ready = bus.out_ready;
`else
  assign hold_ready = 1'b0;
`endif
  assign bus.in_ready = !reset && (state_q == ACCUM || hold_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign close_beat = cnt_inc == CNT_W'(WINDOW) || bus.flush;
  // acc/cnt are cleared when a window closes, so in HOLD they already seed a fresh window
  _or16 u_or (.a_i(acc_q), .b_i(bus.in_data), .y_o(merged));
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_data = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_any = |out_data_q;
  always_comb begin
    state_d = (state_q == HOLD && bus.out_ready) ? ACCUM : state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_data_d = out_data_q;
    out_count_d = out_count_q;
    if (accept && close_beat) begin
      state_d = HOLD;
      acc_d = '0;
      cnt_d = '0;
      out_data_d = merged;
      out_count_d = cnt_inc;
    end else if (accept) begin
      acc_d = merged;
      cnt_d = cnt_inc;
    end else if (state_q == ACCUM && bus.flush && cnt_q != '0) begin
      state_d = HOLD;
      acc_d = '0;
      cnt_d = '0;
      out_data_d = acc_q;
      out_count_d = cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      out_data_q <= '0;
      out_count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_data_q <= out_data_d;
      out_count_q <= out_count_d;
    end
  end
endmodule

// File: tb/tb__or16_accum.sv
// tb__or16_accum: directed plan plus random traffic against a queue-based window model
module tb__or16_accum;
  import _or16_accum_pkg::*;
  localparam int W = WINDOW_DEF;
  localparam int CW = CNT_W_DEF;
`ifdef OR16_ACCUM_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] win[$];
  bit holding = 1'b0;
  logic [15:0] exp_data = '0;
  int exp_cnt = 0;
  _or16_accum_if #(.CNT_W(CW)) bus ();
  _or16_accum #(.WINDOW(W), .CNT_W(CW)) dut (.clk(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void close_window();
    exp_data = '0;
    foreach (win[i]) exp_data |= win[i];
    exp_cnt = win.size();
    holding = 1'b1;
    win.delete();
  endfunction
  // one cycle: drive at negedge, check ready, model the edge, check outputs at next negedge
  task automatic step(bit v, logic [15:0] d, bit f, bit r, bit rs);
    bit exp_ready;
    rst = rs;
    bus.in_valid = v;
    bus.in_data = d;
    bus.flush = f;
    bus.out_ready = r;
    exp_ready = !rs && (!holding || (OVL && r));
    #1;
    chk("in_ready", bus.in_ready, exp_ready);
    @(posedge clk);
    if (rs) begin
      win.delete();
      holding = 1'b0;
    end else begin
      if (holding && r) holding = 1'b0;
      if (exp_ready && v) begin
        win.push_back(d);
        if (win.size() == W || f) close_window();
      end else if (f && win.size() > 0) close_window();
    end
    @(negedge clk);
    chk("out_valid", bus.out_valid, holding);
    if (holding) begin
      chk("out_data", bus.out_data, exp_data);
      chk("out_count", bus.out_count, exp_cnt);
      chk("out_any", bus.out_any, |exp_data);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    step(1, 16'hFFFF, 1, 1, 1);
    chk("rst_data", bus.out_data, 16'h0000);
    chk("rst_count", bus.out_count, 0);
    // plan 1: four beats, result the cycle after the last one
    step(1, 16'h0001, 0, 1, 0);
    step(1, 16'h0010, 0, 1, 0);
    step(1, 16'h0100, 0, 1, 0);
    step(1, 16'h8000, 0, 1, 0);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_data", bus.out_data, 16'h8111);
    chk("t1_count", bus.out_count, 4);
    chk("t1_any", bus.out_any, 1);
    step(0, 16'h0000, 0, 1, 0);
    // plan 2: backpressure on the result while upstream waits with 00FF
    step(1, 16'h0001, 0, 0, 0);
    step(1, 16'h0010, 0, 0, 0);
    step(1, 16'h0100, 0, 0, 0);
    step(1, 16'h8000, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h00FF, 0, 0, 0);
    chk("t2_hold", bus.out_data, 16'h8111);
    step(1, 16'h00FF, 0, 1, 0);
    step(1, 16'h00FF, 1, 1, 0);
    step(0, 16'h0000, 0, 1, 0);
    // plan 3: flush alone, then flush on an empty window
    step(1, 16'h00F0, 0, 0, 0);
    step(1, 16'h0F00, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    chk("t3_data", bus.out_data, 16'h0FF0);
    chk("t3_count", bus.out_count, 2);
    step(0, 16'h0000, 0, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    chk("t3_empty", bus.out_valid, 0);
    // plan 4: flush together with a beat
    step(1, 16'h0001, 0, 0, 0);
    step(1, 16'h0002, 1, 0, 0);
    chk("t4_data", bus.out_data, 16'h0003);
    chk("t4_count", bus.out_count, 2);
    step(0, 16'h0000, 0, 1, 0);
    // plan 5: all-zero window, then reset mid-window
    for (int i = 0; i < 4; i++) step(1, 16'h0000, 0, 0, 0);
    chk("t5_any", bus.out_any, 0);
    chk("t5_count", bus.out_count, 4);
    step(0, 16'h0000, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h1111, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    step(1, 16'h0002, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0);
    chk("t5_excl", bus.out_data, 16'h0002);
    // plan 6: reset in HOLD, then a beat riding the handshake
    step(0, 16'h0000, 0, 0, 1);
    chk("t6_rst", bus.out_valid, 0);
    for (int i = 0; i < 4; i++) step(1, 16'h0008, 0, 0, 0);
    step(1, 16'h4000, 0, 1, 0);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 0, 1, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(3) != 0, 16'(1 << $urandom_range(15)) | 16'($urandom_range(1) ? $urandom : 0),
           $urandom_range(7) == 0, $urandom_range(1) == 1, $urandom_range(99) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
